// File: rtl/ripple_carry_adder_4b_pkg.sv
// Shared definitions for the ripple-carry adder slice: the default width and
// the packed {carry, sum} result type that callers use to view the outputs as
// a single unsigned number.
package ripple_carry_adder_4b_pkg;

    localparam int ADDER_WIDTH_DEFAULT = 4;

    // {Cout, S} for the default width, as one (WIDTH+1)-bit unsigned value.
    typedef struct packed {
        logic                           carry;
        logic [ADDER_WIDTH_DEFAULT-1:0] sum;
    } adder_result_t;

    // Reference sum used by checkers: A + B + Cin without truncation.
    function automatic logic [ADDER_WIDTH_DEFAULT:0] ref_add(
        input logic [ADDER_WIDTH_DEFAULT-1:0] a,
        input logic [ADDER_WIDTH_DEFAULT-1:0] b,
        input logic                           ci
    );
        return {1'b0, a} + {1'b0, b} + {{ADDER_WIDTH_DEFAULT{1'b0}}, ci};
    endfunction

endpackage

// File: rtl/ripple_carry_adder_4b_if.sv
// Operand/result bundle for the ripple-carry adder. The master side presents
// operands with in_valid; the slave side (the adder) returns the registered
// sum, carry-out and out_valid one cycle later.
interface ripple_carry_adder_4b_if
    import ripple_carry_adder_4b_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
);
    logic             in_valid;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic [WIDTH-1:0] S;
    logic             Cout;
    logic             out_valid;

    modport master (
        output in_valid, A, B, Cin,
        input  S, Cout, out_valid
    );

    modport slave (
        input  in_valid, A, B, Cin,
        output S, Cout, out_valid
    );
endinterface

// File: rtl/ripple_carry_adder_4b_full_adder.sv
// One-bit full-adder cell; the adder chains WIDTH of these through co -> ci.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    // Propagate term is shared by the sum and the carry.
    always_comb begin
        p  = a ^ b;
        s  = p ^ ci;
        co = (a & b) | (ci & p);
    end
endmodule

// File: rtl/ripple_carry_adder_4b.sv
// Unsigned ripple-carry adder with a single output register stage.
// {Cout, S} = A + B + Cin, visible one cycle after in_valid, with out_valid
// marking which cycles carry a fresh result. The timing path is Cin/A[0]/B[0]
// through all WIDTH carry cells into the Cout flop.
module ripple_carry_adder_4b
    import ripple_carry_adder_4b_pkg::*;
#(
    parameter int WIDTH = ADDER_WIDTH_DEFAULT
) (
    input logic                   clk,
    input logic                   rst,
    ripple_carry_adder_4b_if.slave bus
);
    // carry[i] is the carry into bit i; carry[WIDTH] is the combinational Cout.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_next;

    assign carry[0] = bus.Cin;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            full_adder u_fa (
                .a  (bus.A[gi]),
                .b  (bus.B[gi]),
                .ci (carry[gi]),
                .s  (sum_next[gi]),
                .co (carry[gi+1])
            );
        end
    endgenerate

    // Output register: reset wins over a coincident operation; idle cycles
    // keep the last result but drop out_valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.S         <= '0;
            bus.Cout      <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.S    <= sum_next;
                bus.Cout <= carry[WIDTH];
            end
        end
    end

`ifndef SYNTHESIS
    // The registered result must match a plain '+' of the operands one cycle on.
    a_sum_matches : assert property (
        @(posedge clk) disable iff (rst)
        bus.in_valid |=> ({bus.Cout, bus.S} ==
            $past({1'b0, bus.A} + {1'b0, bus.B} + {{WIDTH{1'b0}}, bus.Cin}))
    ) else $error("adder result differs from A+B+Cin");
`endif

endmodule

// File: tb/tb_ripple_carry_adder_4b.sv
// Directed bench for ripple_carry_adder_4b at WIDTH = 4: reset, a table of
// back-to-back sums, hold, reset mid-operation and a full operand sweep.
module tb_ripple_carry_adder_4b;
    import ripple_carry_adder_4b_pkg::*;

    localparam int W = 4;

    typedef struct {
        string          name;
        logic [W-1:0]   a;
        logic [W-1:0]   b;
        logic           cin;
        logic [W-1:0]   s;
        logic           cout;
    } vec_t;

    logic clk;
    logic rst;
    int   tests_run;
    int   tests_failed;

    ripple_carry_adder_4b_if #(.WIDTH(W)) bus ();

    ripple_carry_adder_4b #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance past the next rising edge so outputs are settled when sampled.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic ci);
        bus.in_valid = v;
        bus.A        = a;
        bus.B        = b;
        bus.Cin      = ci;
    endtask

    // Compare {out_valid, Cout, S} against the required triple.
    task automatic check(input string name, input logic ov,
                         input logic co, input logic [W-1:0] s);
        tests_run++;
        if ({bus.out_valid, bus.Cout, bus.S} !== {ov, co, s}) begin
            tests_failed++;
            $display("[TB] FAIL %s: got ov=%b cout=%b s=%0d, need ov=%b cout=%b s=%0d",
                     name, bus.out_valid, bus.Cout, bus.S, ov, co, s);
        end else begin
            $display("[TB] ok   %s: ov=%b cout=%b s=%0d", name, ov, co, s);
        end
    endtask

    vec_t vecs[5];

    initial begin
        tests_run    = 0;
        tests_failed = 0;

        vecs[0] = '{"add_3_3",      4'd3,  4'd3,  1'b0, 4'd6,  1'b0};
        vecs[1] = '{"add_8_7",      4'd8,  4'd7,  1'b0, 4'd15, 1'b0};
        vecs[2] = '{"add_6_6",      4'd6,  4'd6,  1'b0, 4'd12, 1'b0};
        vecs[3] = '{"wrap_15_0_c1", 4'd15, 4'd0,  1'b1, 4'd0,  1'b1};
        vecs[4] = '{"max_15_15_c1", 4'd15, 4'd15, 1'b1, 4'd15, 1'b1};

        // Reset held for two cycles with live operands.
        rst = 1'b1;
        drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
        step();
        check("reset_cycle0", 1'b0, 1'b0, 4'd0);
        drive(1'b1, 4'($urandom), 4'($urandom), 1'($urandom));
        step();
        check("reset_cycle1", 1'b0, 1'b0, 4'd0);
        rst = 1'b0;

        // Table vectors streamed back-to-back.
        drive(1'b1, vecs[0].a, vecs[0].b, vecs[0].cin);
        for (int i = 0; i < 5; i++) begin
            step();
            if (i + 1 < 5)
                drive(1'b1, vecs[i+1].a, vecs[i+1].b, vecs[i+1].cin);
            else
                drive(1'b0, 4'd0, 4'd0, 1'b0);
            check(vecs[i].name, 1'b1, vecs[i].cout, vecs[i].s);
        end
        step();
        check("idle_after_table", 1'b0, 1'b1, 4'd15);

        // Hold: result stays while in_valid is low and operands wander.
        drive(1'b1, 4'd5, 4'd9, 1'b0);
        step();
        check("hold_load_5_9", 1'b1, 1'b0, 4'd14);
        drive(1'b0, 4'd12, 4'd11, 1'b1);
        step();
        check("hold_idle1", 1'b0, 1'b0, 4'd14);
        drive(1'b0, 4'd7, 4'd15, 1'b1);
        step();
        check("hold_idle2", 1'b0, 1'b0, 4'd14);

        // Reset mid-operation discards the coincident operation.
        drive(1'b1, 4'd15, 4'd15, 1'b1);
        step();
        check("pre_reset_load", 1'b1, 1'b1, 4'd15);
        rst = 1'b1;
        drive(1'b1, 4'd9, 4'd9, 1'b0);
        step();
        check("reset_mid_op", 1'b0, 1'b0, 4'd0);
        rst = 1'b0;
        step();
        check("post_reset_first", 1'b1, 1'b1, 4'd2);
        drive(1'b0, 4'd0, 4'd0, 1'b0);
        step();
        check("post_reset_idle", 1'b0, 1'b1, 4'd2);

        // Exhaustive sweep streamed back-to-back; expected from plain '+'.
        begin
            adder_result_t exp_r;
            logic [W-1:0]  pa, pb;
            logic          pc;
            for (int k = 0; k < 512; k++) begin
                pa = 4'(k >> 5);
                pb = 4'(k >> 1);
                pc = 1'(k);
                drive(1'b1, pa, pb, pc);
                step();
                exp_r = ref_add(pa, pb, pc);
                check($sformatf("sweep_%0d+%0d+%0d", pa, pb, pc),
                      1'b1, exp_r.carry, exp_r.sum);
            end
            drive(1'b0, 4'd0, 4'd0, 1'b0);
            step();
            check("sweep_drain", 1'b0, 1'b1, 4'd15);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule

// File: doc/ripple_carry_adder_4b.md
# ripple_carry_adder_4b

Parameterised unsigned ripple-carry adder, default 4 bits wide, with a registered sum and carry-out. The carry chain is built from a generate/for loop of one-bit full-adder cells. The result is captured on the clock edge after the operands are applied. It serves as a small arithmetic leaf block for datapaths that need a one-cycle, carry-in/carry-out adder.

## Interface
Parameters:
- WIDTH, default 4: operand and sum width in bits; legal range 1 to 32.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous and active-high.
- in_valid  input  1  marks A/B/Cin as a valid operation this cycle.
- A  input  WIDTH  unsigned operand A.
- B  input  WIDTH  unsigned operand B.
- Cin  input  1  carry into bit 0.
- S  output  WIDTH  registered sum, S = (A + B + Cin) mod 2^WIDTH.
- Cout  output  1  registered carry out of bit WIDTH-1.
- out_valid  output  1  high for one cycle when S/Cout hold a result from an in_valid cycle.

## Operation
- Carry chain: c[0] = Cin.
- For i = 0..WIDTH-1: s[i] = A[i] ^ B[i] ^ c[i], and c[i+1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i])).
- The combinational carry-out is c[WIDTH].
- The result is unsigned with no saturation; {Cout, S} equals A + B + Cin exactly, as a (WIDTH+1)-bit value.
- On a rising clk edge with in_valid = 1: S <= s, Cout <= c[WIDTH], out_valid <= 1.
- On a rising clk edge with in_valid = 0:
  - S and Cout hold their previous values.
  - out_valid <= 0.
- X/Z on A, B or Cin is not defined. The environment drives known values whenever in_valid = 1.
- There is no backpressure. A new operation is accepted every cycle.
- There is no state machine; the block is one pipeline register stage.

## Timing
- Latency is exactly 1 cycle: operands sampled at edge N appear on S/Cout/out_valid after edge N.
- Throughput is 1 operation per cycle. Back-to-back in_valid produces back-to-back out_valid.
- Reset values, applied on a rising clk edge with rst = 1: S = 0, Cout = 0, out_valid = 0.
- rst has priority over in_valid. An operation presented in the same cycle as rst is discarded.
- Reset mid-stream clears any pending result. The first valid output after reset comes one cycle after the first in_valid accepted with rst = 0.
- Outputs are glitch-free because they come straight from flops.
- The combinational critical path is Cin/A[0]/B[0] through WIDTH carry cells into the Cout flop. This path is the timing constraint.
- Wrap-around: an all-ones sum plus carry gives S = 0 and Cout = 1, with no other side effect.

## Structure
- Shared package holds:
  - ADDER_WIDTH_DEFAULT = 4.
  - A typedef for the (WIDTH+1)-bit {carry, sum} result.
- Sub-module full_adder:
  - Inputs a, b, ci; outputs s, co; purely combinational.
  - Instantiated WIDTH times inside a generate for-loop with the carry wired bit i to bit i+1.
- Top level contains:
  - the generate loop;
  - the output register (S, Cout, out_valid) with synchronous reset;
  - an optional simulation-only assertion that {Cout, S} equals A + B + Cin one cycle after in_valid.

## Test plan
- Reset check: hold rst = 1 for 2 cycles with random operands and in_valid = 1 -> S = 0, Cout = 0, out_valid = 0 throughout.
- Basic sums, Cin = 0, applied on consecutive valid cycles:
  - A = 3, B = 3 -> S = 6, Cout = 0.
  - A = 8, B = 7 -> S = 15, Cout = 0.
  - A = 6, B = 6 -> S = 12, Cout = 0.
  - Each result appears one cycle later with out_valid = 1.
- Carry ripple and wrap: A = 15, B = 0, Cin = 1 -> S = 0, Cout = 1. A = 15, B = 15, Cin = 1 -> S = 15, Cout = 1.
- Hold behaviour: a valid 5 + 9 is followed by in_valid = 0 while A/B change -> S stays 14, Cout stays 0, out_valid drops to 0 after one cycle.
- Reset mid-operation: in_valid = 1 with A = 9, B = 9 in the same cycle as rst = 1 -> next cycle S = 0, Cout = 0, out_valid = 0; the next valid operation then produces a correct result.
- Exhaustive sweep: all 512 combinations of A, B and Cin for WIDTH = 4, streamed back-to-back -> each {Cout, S} equals A + B + Cin one cycle later.
